// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 round sequencer driving an external round datapath
//
// Purpose:
//   Accepts one plaintext/key pair per handshake. It holds the cipher state and the
//   current round key. It steps an external combinational round datapath once per clock
//   for NR rounds, then presents the ciphertext until the consumer takes it.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous abort to IDLE (wins over every handshake)
//   in_valid/in_ready   input handshake; in_data = plaintext, in_key = cipher key
//   dp_state, dp_rkey   state register and previous round key, fed to the datapath
//   dp_round, dp_final  round index (1..NR in ROUND, else 0), last-round flag
//   dp_rk_next          expanded round key for dp_round (from the datapath)
//   dp_result           round output (from the datapath)
//   out_valid/out_ready output handshake; out_data = ciphertext
//   busy                high while a block is in flight or waiting to be taken
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic [127:0]  in_key,
    output logic [127:0]  dp_state,
    output logic [127:0]  dp_rkey,
    output logic [RW-1:0] dp_round,
    output logic          dp_final,
    input  logic [127:0]  dp_rk_next,
    input  logic [127:0]  dp_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    fsm_e          fsm_q;
    logic [127:0]  state_q;
    logic [127:0]  key_q;
    logic [RW-1:0] round_q;
    logic          out_valid_q;
    logic          busy_q;

    logic          last_round;
    logic          accept;
    logic [127:0]  load_state_d;

    // round_q is kept at 0 whenever the FSM is not in ROUND, so it can drive dp_round
    // directly and dp_final needs no state decode.
    assign last_round   = (round_q == RW'(NR));
    assign in_ready     = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
    // A handshake coinciding with flush is ignored, so flush masks the accept.
    assign accept       = in_valid && in_ready && !flush;
    // Initial AddRoundKey is folded into the load.
    assign load_state_d = in_data ^ in_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            fsm_q       <= S_IDLE;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        fsm_q       <= S_ROUND;
                        state_q     <= load_state_d;
                        key_q       <= in_key;
                        round_q     <= RW'(1);
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else if ((fsm_q == S_DONE) && out_ready) begin
                        fsm_q       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                S_ROUND: begin
                    state_q <= dp_result;
                    key_q   <= dp_rk_next;
                    if (last_round) begin
                        fsm_q       <= S_DONE;
                        round_q     <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + RW'(1);
                    end
                end
                default: begin
                    fsm_q       <= S_IDLE;
                    round_q     <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign dp_state  = state_q;
    assign dp_rkey   = key_q;
    assign dp_round  = round_q;
    assign dp_final  = last_round;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? state_q : '0;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - randomized self-checking bench with AES reference model and datapath
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_data = '0;
    logic [127:0]  in_key = '0;
    logic [127:0]  dp_state;
    logic [127:0]  dp_rkey;
    logic [RW-1:0] dp_round;
    logic          dp_final;
    logic [127:0]  dp_rk_next;
    logic [127:0]  dp_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [127:0]  out_data;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbox [256];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .dp_state   (dp_state),
        .dp_rkey    (dp_rkey),
        .dp_round   (dp_round),
        .dp_final   (dp_final),
        .dp_rk_next (dp_rk_next),
        .dp_result  (dp_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // One AES round on a 128-bit state, byte 0 in bits [127:120], column-major layout.
    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                              input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   t0, t1, t2, t3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, t0) ^ gmul(8'h03, t1) ^ t2 ^ t3;
                b[4*c+1] = t0 ^ gmul(8'h02, t1) ^ gmul(8'h03, t2) ^ t3;
                b[4*c+2] = t0 ^ t1 ^ gmul(8'h02, t2) ^ gmul(8'h03, t3);
                b[4*c+3] = gmul(8'h03, t0) ^ t1 ^ t2 ^ gmul(8'h02, t3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ rk;
    endfunction

    // Datapath key step: derives round key r from round key r-1, rcon by repeated doubling.
    function automatic logic [127:0] key_step(input logic [127:0] k, input int r);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t, n0, n1, n2, n3;
        for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Reference key schedule, FIPS-197 word recurrence with a tabulated Rcon.
    function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
        logic [31:0] w [4*(NR+1)];
        logic [7:0]  rcon_tab [11];
        logic [31:0] t;
        rcon_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] st = pt ^ ref_rk(key, 0);
        for (int r = 1; r <= NR; r++) st = round_fn(st, ref_rk(key, r), r == NR);
        return st;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    assign dp_rk_next = key_step(dp_rkey, int'(dp_round));
    assign dp_result  = round_fn(dp_state, dp_rk_next, dp_final);

    // Full block: accept, per-round sequencing, ciphertext, bp cycles of backpressure, drain.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp, input int bp);
        logic [127:0] held;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = pt; in_key = key; out_ready = (bp == 0);
        @(negedge clk);
        check("acc_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = rnd128(); in_key = rnd128();
        for (int r = 1; r <= NR; r++) begin
            @(negedge clk);
            check("seq_round", dp_round, r);
            check("seq_final", dp_final, r == NR);
            check("seq_rkey", dp_rkey, ref_rk(key, r - 1));
            check("seq_no_valid", out_valid, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        check("done_valid", out_valid, 1'b1);
        check("done_data", out_data, exp);
        check("done_busy", busy, 1'b1);
        held = exp;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, held);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_round", dp_round, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("drain_valid", out_valid, 1'b0);
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic start_block(input logic [127:0] pt, input logic [127:0] key, input logic ordy);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = pt; in_key = key; out_ready = ordy;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin : main
        logic [127:0] a_pt, a_key, b_pt, b_key, ea, eb;
        int seen;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dp_round", dp_round, 0);
        check("rst_dp_final", dp_final, 1'b0);
        check("rst_out_data", out_data, 128'h0);
        rst = 1'b0;

        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

        for (int i = 0; i < 6; i++) begin
            a_pt = rnd128(); a_key = rnd128();
            run_block(a_pt, a_key, aes_ref(a_pt, a_key), int'($urandom_range(0, 4)));
        end

        a_pt = rnd128(); a_key = rnd128();
        run_block(a_pt, a_key, aes_ref(a_pt, a_key), 20);

        // Back-to-back: in_valid held, second block accepted on the DONE handshake edge.
        a_pt = rnd128(); a_key = rnd128(); b_pt = rnd128(); b_key = rnd128();
        ea = aes_ref(a_pt, a_key); eb = aes_ref(b_pt, b_key);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = a_pt; in_key = a_key; out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = b_pt; in_key = b_key;
        repeat (NR) @(posedge clk);
        @(negedge clk);
        check("b2b_a_valid", out_valid, 1'b1);
        check("b2b_a_data", out_data, ea);
        check("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_b_round1", dp_round, 1);
        check("b2b_b_busy", busy, 1'b1);
        repeat (NR) @(posedge clk);
        @(negedge clk);
        check("b2b_b_valid", out_valid, 1'b1);
        check("b2b_b_data", out_data, eb);
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle", busy, 1'b0);

        // Flush at round 5: block is dropped, no out_valid for it.
        start_block(rnd128(), rnd128(), 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("fl_at_round5", dp_round, 5);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl_busy", busy, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        check("fl_round", dp_round, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("fl_no_output", seen, 0);
        a_pt = rnd128(); a_key = rnd128();
        run_block(a_pt, a_key, aes_ref(a_pt, a_key), 1);

        // Flush coinciding with a DONE handshake and a pending in_valid: both ignored.
        start_block(rnd128(), rnd128(), 1'b0);
        repeat (NR) @(posedge clk);
        @(negedge clk);
        check("fd_valid", out_valid, 1'b1);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = rnd128(); in_key = rnd128();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fd_out_valid", out_valid, 1'b0);
        check("fd_busy", busy, 1'b0);
        check("fd_round", dp_round, 0);

        // Asynchronous reset between clock edges mid-ROUND.
        start_block(rnd128(), rnd128(), 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_in_ready", in_ready, 1'b1);
        check("ar_state", dp_state, 128'h0);
        check("ar_rkey", dp_rkey, 128'h0);
        check("ar_round", dp_round, 0);
        @(negedge clk);
        rst = 1'b0;
        a_pt = rnd128(); a_key = rnd128();
        run_block(a_pt, a_key, aes_ref(a_pt, a_key), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
